// File: rtl/speicher_pkg.sv
// Shared definitions for the memory arbiter: default widths, one-hot state codes, grant codes.
// The optional round-robin arbitration is enabled by defining SPEICHER_ARBITER_ROUND_ROBIN_EN.
package speicher_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [3:0] ST_IDLE      = 4'b0001;
  localparam logic [3:0] ST_BEFEHL    = 4'b0010;
  localparam logic [3:0] ST_LESEN     = 4'b0100;
  localparam logic [3:0] ST_SCHREIBEN = 4'b1000;

  typedef enum logic [3:0] {
    IDLE      = ST_IDLE,
    BEFEHL    = ST_BEFEHL,
    LESEN     = ST_LESEN,
    SCHREIBEN = ST_SCHREIBEN
  } zustand_t;

  // Grant decision produced by the selector while the arbiter is idle
  localparam logic [1:0] GNT_NONE      = 2'd0;
  localparam logic [1:0] GNT_BEFEHL    = 2'd1;
  localparam logic [1:0] GNT_LESEN     = 2'd2;
  localparam logic [1:0] GNT_SCHREIBEN = 2'd3;

endpackage

// File: rtl/speicher_auswahl.sv
// Combinational grant selection: done-pulse masking, store-over-load, and port priority.
// With SPEICHER_ARBITER_ROUND_ROBIN_EN a contested grant goes to the port not served last.
module speicher_auswahl
  import speicher_pkg::*;
(
  input  logic       befehl_anfrage,
  input  logic       lade_anfrage,
  input  logic       speicher_anfrage,
  input  logic       befehl_maske,
  input  logic       daten_maske,
`ifdef SPEICHER_ARBITER_ROUND_ROBIN_EN
  input  logic       letzter_daten,
`endif
  output logic [1:0] grant
);

  logic befehl_ok;
  logic daten_ok;
  logic daten_gewinnt;

  // A port whose done pulse is visible this cycle is still holding its old request
  assign befehl_ok = befehl_anfrage & ~befehl_maske;
  assign daten_ok  = (lade_anfrage | speicher_anfrage) & ~daten_maske;

`ifdef SPEICHER_ARBITER_ROUND_ROBIN_EN
  assign daten_gewinnt = daten_ok & (~befehl_ok | ~letzter_daten);
`else
  assign daten_gewinnt = daten_ok;
`endif

  always_comb begin
    grant = GNT_NONE;
    if (daten_gewinnt) begin
      grant = speicher_anfrage ? GNT_SCHREIBEN : GNT_LESEN;
    end else if (befehl_ok) begin
      grant = GNT_BEFEHL;
    end
  end

endmodule

// File: rtl/speicher_arbiter.sv
// Arbiter sharing one memory between an instruction-fetch port and a load/store data port.
// Defining SPEICHER_ARBITER_ROUND_ROBIN_EN replaces fixed data-first priority with round-robin.
module speicher_arbiter
  import speicher_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              BefehlAnfrage,
  input  logic [ADDR_W-1:0] BefehlAdresse,
  output logic [DATA_W-1:0] BefehlDaten,
  output logic              BefehlGeladen,
  input  logic              LadeAnfrage,
  input  logic              SpeicherAnfrage,
  input  logic [ADDR_W-1:0] DatenAdresse,
  input  logic [DATA_W-1:0] DatenSchreib,
  output logic [DATA_W-1:0] DatenLese,
  output logic              DatenGeladen,
  output logic              DatenGespeichert,
  output logic [ADDR_W-1:0] MemAdresse,
  output logic [DATA_W-1:0] MemSchreibDaten,
  output logic              MemLesen,
  output logic              MemSchreiben,
  input  logic [DATA_W-1:0] MemLeseDaten,
  input  logic              MemFertig
);

  zustand_t          state_reg;
  zustand_t          state_next;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] adresse_reg;
  logic [DATA_W-1:0] schreib_daten_reg;
  logic [DATA_W-1:0] befehl_daten_reg;
  logic [DATA_W-1:0] daten_lese_reg;
  logic              befehl_geladen_reg;
  logic              daten_geladen_reg;
  logic              daten_gespeichert_reg;
`ifdef SPEICHER_ARBITER_ROUND_ROBIN_EN
  logic              letzter_daten_reg;
`endif

  speicher_auswahl u_auswahl (
    .befehl_anfrage   (BefehlAnfrage),
    .lade_anfrage     (LadeAnfrage),
    .speicher_anfrage (SpeicherAnfrage),
    .befehl_maske     (befehl_geladen_reg),
    .daten_maske      (daten_geladen_reg | daten_gespeichert_reg),
`ifdef SPEICHER_ARBITER_ROUND_ROBIN_EN
    .letzter_daten    (letzter_daten_reg),
`endif
    .grant            (grant)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        case (grant)
          GNT_BEFEHL:    state_next = BEFEHL;
          GNT_LESEN:     state_next = LESEN;
          GNT_SCHREIBEN: state_next = SCHREIBEN;
          default:       state_next = IDLE;
        endcase
      end
      BEFEHL, LESEN, SCHREIBEN: begin
        if (MemFertig) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg             <= IDLE;
      adresse_reg           <= '0;
      schreib_daten_reg     <= '0;
      befehl_daten_reg      <= '0;
      daten_lese_reg        <= '0;
      befehl_geladen_reg    <= 1'b0;
      daten_geladen_reg     <= 1'b0;
      daten_gespeichert_reg <= 1'b0;
`ifdef SPEICHER_ARBITER_ROUND_ROBIN_EN
      letzter_daten_reg     <= 1'b0;
`endif
    end else begin
      state_reg             <= state_next;
      befehl_geladen_reg    <= 1'b0;
      daten_geladen_reg     <= 1'b0;
      daten_gespeichert_reg <= 1'b0;

      // Latching at grant keeps the memory command stable even if the requester changes its inputs
      if (state_reg == IDLE && grant != GNT_NONE) begin
        adresse_reg <= (grant == GNT_BEFEHL) ? BefehlAdresse : DatenAdresse;
        if (grant == GNT_SCHREIBEN) begin
          schreib_daten_reg <= DatenSchreib;
        end
`ifdef SPEICHER_ARBITER_ROUND_ROBIN_EN
        letzter_daten_reg <= (grant != GNT_BEFEHL);
`endif
      end

      if (MemFertig) begin
        case (state_reg)
          BEFEHL: begin
            befehl_daten_reg   <= MemLeseDaten;
            befehl_geladen_reg <= 1'b1;
          end
          LESEN: begin
            daten_lese_reg    <= MemLeseDaten;
            daten_geladen_reg <= 1'b1;
          end
          SCHREIBEN: daten_gespeichert_reg <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign MemLesen         = (state_reg == BEFEHL) || (state_reg == LESEN);
  assign MemSchreiben     = (state_reg == SCHREIBEN);
  assign MemAdresse       = adresse_reg;
  assign MemSchreibDaten  = schreib_daten_reg;
  assign BefehlDaten      = befehl_daten_reg;
  assign DatenLese        = daten_lese_reg;
  assign BefehlGeladen    = befehl_geladen_reg;
  assign DatenGeladen     = daten_geladen_reg;
  assign DatenGespeichert = daten_gespeichert_reg;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Scoreboard bench for speicher_arbiter: randomized port requests, a responding memory model,
// and a transaction-level reference model predicting grant order and read data.
module tb_speicher_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        BefehlAnfrage;
  logic [31:0] BefehlAdresse;
  logic [31:0] BefehlDaten;
  logic        BefehlGeladen;
  logic        LadeAnfrage;
  logic        SpeicherAnfrage;
  logic [31:0] DatenAdresse;
  logic [31:0] DatenSchreib;
  logic [31:0] DatenLese;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic [31:0] MemAdresse;
  logic [31:0] MemSchreibDaten;
  logic        MemLesen;
  logic        MemSchreiben;
  logic [31:0] MemLeseDaten;
  logic        MemFertig;

  speicher_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .BefehlAnfrage(BefehlAnfrage), .BefehlAdresse(BefehlAdresse),
    .BefehlDaten(BefehlDaten), .BefehlGeladen(BefehlGeladen),
    .LadeAnfrage(LadeAnfrage), .SpeicherAnfrage(SpeicherAnfrage),
    .DatenAdresse(DatenAdresse), .DatenSchreib(DatenSchreib),
    .DatenLese(DatenLese), .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
    .MemAdresse(MemAdresse), .MemSchreibDaten(MemSchreibDaten),
    .MemLesen(MemLesen), .MemSchreiben(MemSchreiben),
    .MemLeseDaten(MemLeseDaten), .MemFertig(MemFertig)
  );

  always #5 Clock = ~Clock;

  // kind: 0 = fetch, 1 = load, 2 = store
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        cmd_q[$];
  txn_t        done_q[$];
  int          len_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] resp_mem[logic [31:0]];
  bit          last_data = 1'b0;
  logic [31:0] exp_befehl = '0;
  logic [31:0] exp_lese = '0;
  int          forced_delay = -1;
  bit          hold_resp = 1'b0;
  int          last_cmd_len = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] resp_read(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
  endfunction

  function automatic txn_t make(input int kind, input logic [31:0] a, input logic [31:0] w);
    txn_t t;
    t.kind  = kind;
    t.addr  = a;
    t.wdata = (kind == 2) ? w : 32'h0;
    t.rdata = (kind == 2) ? 32'h0 : ref_read(a);
    if (kind == 2) ref_mem[a] = w;
    return t;
  endfunction

  function automatic void push(input txn_t t);
    cmd_q.push_back(t);
    done_q.push_back(t);
  endfunction

  // Reference: store beats load on the data port; contention between ports goes to data
  // (fixed) or to whichever port was not served last (round-robin).
  function automatic void plan_order(input bit f, input bit l, input bit s,
                                     input logic [31:0] fa, input logic [31:0] da,
                                     input logic [31:0] dw);
    bit fp = f;
    bit lp = l;
    bit sp = s;
    bit take_data;
    while (fp || lp || sp) begin
      if (fp && (lp || sp)) begin
`ifdef SPEICHER_ARBITER_ROUND_ROBIN_EN
        take_data = !last_data;
`else
        take_data = 1'b1;
`endif
      end else begin
        take_data = lp || sp;
      end
      if (take_data) begin
        if (sp) begin
          push(make(2, da, dw));
          sp = 1'b0;
        end else begin
          push(make(1, da, 32'h0));
          lp = 1'b0;
        end
        last_data = 1'b1;
      end else begin
        push(make(0, fa, 32'h0));
        fp = 1'b0;
        last_data = 1'b0;
      end
    end
  endfunction

  // Requests are held until their own done pulse, exercising the done-cycle masking.
  task automatic issue(input bit f, input bit l, input bit s, input logic [31:0] fa,
                       input logic [31:0] da, input logic [31:0] dw);
    bit single = (int'(f) + int'(l) + int'(s)) == 1;
    $display("issue fetch=%0b load=%0b store=%0b fa=%h da=%h dw=%h last_data=%0b",
             f, l, s, fa, da, dw, last_data);
    plan_order(f, l, s, fa, da, dw);
    @(negedge Clock);
    BefehlAdresse   = fa;
    DatenAdresse    = da;
    DatenSchreib    = dw;
    BefehlAnfrage   = f;
    LadeAnfrage     = l;
    SpeicherAnfrage = s;
    for (int c = 0; c < 200 && (BefehlAnfrage || LadeAnfrage || SpeicherAnfrage); c++) begin
      @(negedge Clock);
      if (BefehlGeladen)    BefehlAnfrage = 1'b0;
      if (DatenGeladen)     LadeAnfrage = 1'b0;
      if (DatenGespeichert) SpeicherAnfrage = 1'b0;
      if (single && (MemLesen || MemSchreiben)) begin
        BefehlAdresse = $urandom;
        DatenAdresse  = $urandom;
        DatenSchreib  = $urandom;
      end
    end
    if (BefehlAnfrage || LadeAnfrage || SpeicherAnfrage) begin
      check("issue_timeout", 32'd1, 32'd0);
      BefehlAnfrage   = 1'b0;
      LadeAnfrage     = 1'b0;
      SpeicherAnfrage = 1'b0;
    end
  endtask

  // Memory responder: completes after a random (or forced) delay, sometimes strobes while idle.
  initial begin
    int wait_cnt = 0;
    int cur_delay = 0;
    MemFertig    = 1'b0;
    MemLeseDaten = '0;
    forever begin
      @(negedge Clock);
      MemFertig    = 1'b0;
      MemLeseDaten = $urandom;
      if (!(MemLesen || MemSchreiben)) begin
        cur_delay = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
        wait_cnt  = cur_delay;
        if (!Reset && $urandom_range(0, 3) == 0) MemFertig = 1'b1;
      end else if (!hold_resp) begin
        if (wait_cnt == 0) begin
          MemFertig = 1'b1;
          if (MemLesen) MemLeseDaten = resp_read(MemAdresse);
          else resp_mem[MemAdresse] = MemSchreibDaten;
          len_q.push_back(cur_delay);
          wait_cnt = -1;
        end else if (wait_cnt > 0) begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every command start and every done pulse.
  initial begin
    bit   prev_active = 1'b0;
    bit   active;
    bit   have_cur = 1'b0;
    int   cmd_len = 0;
    int   n;
    int   kind_act;
    txn_t cur;
    txn_t t;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        prev_active = 1'b0;
        have_cur    = 1'b0;
        cmd_len     = 0;
      end else begin
        active = MemLesen || MemSchreiben;
        if (MemLesen && MemSchreiben) check("cmd_exclusive", 32'd1, 32'd0);
        if (active && !prev_active) begin
          cmd_len = 0;
          if (cmd_q.size() == 0) begin
            check("unexpected_cmd", 32'd1, 32'd0);
            have_cur = 1'b0;
          end else begin
            cur      = cmd_q.pop_front();
            have_cur = 1'b1;
            check("cmd_kind", {30'd0, MemSchreiben, MemLesen}, (cur.kind == 2) ? 32'd2 : 32'd1);
          end
        end
        if (active) begin
          cmd_len++;
          if (have_cur) begin
            check("MemAdresse", MemAdresse, cur.addr);
            if (cur.kind == 2) check("MemSchreibDaten", MemSchreibDaten, cur.wdata);
          end
        end
        if (!active && prev_active) begin
          last_cmd_len = cmd_len;
          if (len_q.size() != 0) check("cmd_len", cmd_len, len_q.pop_front() + 1);
        end
        n = int'(BefehlGeladen) + int'(DatenGeladen) + int'(DatenGespeichert);
        if (n > 1) check("done_onehot", n, 32'd1);
        if (n >= 1) begin
          kind_act = BefehlGeladen ? 0 : (DatenGeladen ? 1 : 2);
          if (done_q.size() == 0) begin
            check("unexpected_done", kind_act + 1, 32'd0);
          end else begin
            t = done_q.pop_front();
            check("done_kind", kind_act, t.kind);
            if (t.kind == 0) exp_befehl = t.rdata;
            if (t.kind == 1) exp_lese = t.rdata;
            check("BefehlDaten", BefehlDaten, exp_befehl);
            check("DatenLese", DatenLese, exp_lese);
            $display("done kind=%0d addr=%h befehl=%h lese=%h", t.kind, t.addr, BefehlDaten, DatenLese);
          end
        end
        prev_active = active;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt;
    int          combo;
    bit          seen;
    logic [31:0] a;
    Reset           = 1'b1;
    BefehlAnfrage   = 1'b0;
    LadeAnfrage     = 1'b0;
    SpeicherAnfrage = 1'b0;
    BefehlAdresse   = '0;
    DatenAdresse    = '0;
    DatenSchreib    = '0;
    repeat (3) @(negedge Clock);
    check("rst_BefehlDaten", BefehlDaten, 32'h0);
    check("rst_DatenLese", DatenLese, 32'h0);
    check("rst_BefehlGeladen", BefehlGeladen, 32'h0);
    check("rst_DatenGeladen", DatenGeladen, 32'h0);
    check("rst_DatenGespeichert", DatenGespeichert, 32'h0);
    check("rst_MemLesen", MemLesen, 32'h0);
    check("rst_MemSchreiben", MemSchreiben, 32'h0);
    check("rst_MemAdresse", MemAdresse, 32'h0);
    check("rst_MemSchreibDaten", MemSchreibDaten, 32'h0);
    Reset = 1'b0;
    @(negedge Clock);

    // Fetch with completion on the third command cycle
    forced_delay = 2;
    ref_mem[32'h10]  = 32'hDEAD_BEEF;
    resp_mem[32'h10] = 32'hDEAD_BEEF;
    issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
    check("fetch_MemLesen_cycles", last_cmd_len, 32'd3);
    check("fetch_BefehlDaten", BefehlDaten, 32'hDEAD_BEEF);

    // Store, then read it back through the data port
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h20, 32'h1234_5678);
    check("store_MemSchreiben_cycles", last_cmd_len, 32'd3);
    check("store_mem_written", resp_read(32'h20), 32'h1234_5678);
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0);
    check("load_back", DatenLese, 32'h1234_5678);
    forced_delay = -1;

    // Back-to-back port contention
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, 1'b0, 32'h40 + 4 * i, 32'h80 + 4 * i, 32'h0);
    end

    // Randomized mix on a small address window so stores and loads interact
    for (int i = 0; i < 150; i++) begin
      combo = $urandom_range(0, 5);
      issue(combo == 0 || combo == 3 || combo == 4,
            combo == 1 || combo == 3 || combo == 5,
            combo == 2 || combo == 4 || combo == 5,
            32'($urandom_range(0, 7)) << 2, 32'($urandom_range(0, 7)) << 2, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    // Reset while a load waits on a stalled memory
    hold_resp = 1'b1;
    a = 32'h0000_0044;
    cmd_q.push_back(make(1, a, 32'h0));
    @(negedge Clock);
    DatenAdresse = a;
    LadeAnfrage  = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clock);
      seen = MemLesen;
    end
    check("rst_load_started", seen, 32'd1);
    LadeAnfrage = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("midrst_MemLesen", MemLesen, 32'h0);
    check("midrst_MemAdresse", MemAdresse, 32'h0);
    check("midrst_DatenLese", DatenLese, 32'h0);
    check("midrst_BefehlDaten", BefehlDaten, 32'h0);
    check("midrst_DatenGeladen", DatenGeladen, 32'h0);
    hold_resp  = 1'b0;
    last_data  = 1'b0;
    exp_befehl = '0;
    exp_lese   = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge Clock);
      if (DatenGeladen) cnt++;
    end
    check("midrst_no_done", cnt, 32'd0);

    // Arbiter must work normally after the reset
    issue(1'b1, 1'b1, 1'b0, 32'h8, 32'hC, 32'h0);
    issue(1'b0, 1'b1, 1'b1, 32'h0, 32'h18, 32'hCAFE_F00D);
    check("post_rst_load", DatenLese, 32'hCAFE_F00D);

    repeat (4) @(negedge Clock);
    check("cmd_q_empty", cmd_q.size(), 32'd0);
    check("done_q_empty", done_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
